serial_nibble_adder: RTL and testbench
======================================

# serial_nibble_adder

Multi-cycle WIDTH-bit adder/subtractor that sits directly upstream of the team's 4-bit carry-look-ahead adder stage (a[3:0], b[3:0], cin → s[4:0], where s[4] is the carry out). The block slices wide operands into nibbles and feeds one nibble per cycle into a single CLA stage instance. It registers the stage's carry out as the next carry in and assembles the WIDTH-bit result. Valid/ready handshakes sit on both the operand side and the result side, so the block drops into streaming datapaths.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4. N = WIDTH/4 is the nibble count.

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  input  1  operand set {a, b, cin, sub} is valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry in for add; ignored when sub=1.
- sub  input  1  1 computes a − b; 0 computes a + b + cin.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB nibble; for sub, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.

## Operation
- The block contains one instance of the 4-bit CLA stage. The block itself adds no other addition logic.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid & in_ready, the block latches a, beff, and carry reg = c0, clears nibble index idx to 0, and goes to RUN.
    - Add: beff = b and c0 = cin.
    - Sub: beff = ~b and c0 = 1.
  - RUN: stage inputs are a_reg[4·idx+3:4·idx], beff_reg[4·idx+3:4·idx], and carry reg.
    - Each edge writes s[3:0] into sum[4·idx+3:4·idx] and writes s[4] into carry reg, then increments idx.
    - After the edge that processes idx = N−1: cout ← s[4], overflow is computed, and the FSM goes to DONE.
  - DONE: out_valid=1. On out_ready, the FSM goes to IDLE.
- Overflow: overflow = (a_reg[MSB] == beff_reg[MSB]) & (sum[MSB] != a_reg[MSB]), evaluated on the final sum.
- Arithmetic: the result is modulo 2^WIDTH, with carry/borrow reported only through cout.
- in_ready = (state == IDLE) & rst_n. It is combinational and low in RUN and DONE; in_valid is ignored in those states.
- sum, cout, and overflow are stable for the whole DONE state. They retain their last values in IDLE and are overwritten nibble-by-nibble in RUN.
- No same-cycle re-accept: an out handshake and a new in handshake cannot occur on the same edge.
- Reset (rst_n=0 at an edge), in any state including mid-RUN: state → IDLE, idx=0, carry reg=0, sum=0, cout=0, overflow=0, out_valid=0. Any in-flight operation is discarded, and no out_valid is produced for it.

## Timing
- Accept at edge E0. Edges E1..EN process nibbles 0..N−1. out_valid is high from just after EN; for WIDTH=16 that is 4 cycles after accept.
- Result accept at edge Ek → in_ready is high in the following cycle.
- Minimum spacing between accepts is N+2 cycles (6 for WIDTH=16) when out_ready is held high.
- out_valid, sum, cout, and overflow are registered outputs; in_ready is the only combinational output.
- Reset values: out_valid=0, sum=0, cout=0, overflow=0. in_ready=0 while rst_n=0, and 1 in the first cycle after reset deasserts.

## Test plan
- Reset: hold rst_n=0 for 2 edges with random inputs → out_valid=0, sum=0x0000, cout=0, overflow=0, in_ready=0; after rst_n=1, in_ready=1.
- Basic add: a=0x1234, b=0x4321, cin=0, sub=0 → exactly 4 cycles after accept, out_valid=1, sum=0x5555, cout=0, overflow=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. Separately, a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, overflow=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0, overflow=0. Separately, a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, overflow=1.
- Backpressure: out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands → out_valid and sum are held, in_ready=0, and the new operands are not accepted. Then out_ready=1 → IDLE, and the next operands are accepted in the following cycle.
- Mid-operation reset: pull rst_n low for one edge during RUN at idx=2 → IDLE, all outputs zero, and no out_valid for the aborted op. A following add of 0x0001+0x0001 yields 0x0002.

Source files
------------

// File: rtl/serial_nibble_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor built around a single 4-bit CLA stage.
// The block processes one nibble per cycle and chains the carry through a register.

// 4-bit carry-look-ahead stage: s[3:0] is the nibble sum and s[4] is the carry out.
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [4:0] s
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // Look-ahead carries, fully expanded from the generate and propagate terms.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s = {c[4], p ^ c[3:0]};
endmodule

module serial_nibble_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);
   localparam int unsigned N    = WIDTH / 4;
   localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned MSB  = WIDTH - 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [IDXW-1:0]  idx;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] beff_q;
   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [4:0]       stage_s;
   logic [IDXW+1:0]  lo;

   // Bit offset of the nibble currently being processed.
   assign lo    = {idx, 2'b00};
   assign a_nib = a_q[lo +: 4];
   assign b_nib = beff_q[lo +: 4];

   cla4 u_stage (
      .a   (a_nib),
      .b   (b_nib),
      .cin (carry_q),
      .s   (stage_s)
   );

   // Operands are only taken in IDLE and never while reset is asserted.
   assign in_ready = (state == IDLE) & rst_n;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)          state_nxt = RUN;
         RUN:     if (idx == LAST_IDX)   state_nxt = DONE;
         DONE:    if (out_ready)         state_nxt = IDLE;
         default:                        state_nxt = IDLE;
      endcase
   end

   // Operand capture, per-nibble accumulation and result flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx       <= '0;
         carry_q   <= 1'b0;
         a_q       <= '0;
         beff_q    <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state_nxt == DONE);
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction is a + ~b + 1, so invert b and force the carry in.
                  a_q     <= a;
                  beff_q  <= sub ? ~b : b;
                  carry_q <= sub ? 1'b1 : cin;
                  idx     <= '0;
               end
            end
            RUN: begin
               sum[lo +: 4] <= stage_s[3:0];
               carry_q      <= stage_s[4];
               idx          <= idx + IDXW'(1);
               if (idx == LAST_IDX) begin
                  // Final sum MSB comes straight from the stage on this edge.
                  cout     <= stage_s[4];
                  overflow <= (a_q[MSB] == beff_q[MSB]) & (stage_s[3] != a_q[MSB]);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_nibble_adder.sv
// Randomized and directed checks of serial_nibble_adder against an arithmetic reference.
module tb_serial_nibble_adder;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        overflow;

   int errors = 0;
   int checks = 0;

   serial_nibble_adder #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: integer arithmetic on the operands as the spec defines them.
   function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mc, input logic ms,
                                 output logic [15:0] rs, output logic rc, output logic ro);
      int sa, sb, r;
      int unsigned ua, ub, u;
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      ua = 32'(ma);
      ub = 32'(mb);
      if (ms) begin
         r  = sa - sb;
         rc = (ua >= ub);
         u  = ua - ub;
      end else begin
         r  = sa + sb + int'(mc);
         u  = ua + ub + 32'(mc);
         rc = (u > 32'h0000_FFFF);
      end
      rs = u[15:0];
      ro = (r > 32767) || (r < -32768);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One complete operation: accept, wait for result, optional backpressure, release.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input logic ts, input logic [15:0] xs, input logic xc,
                        input logic xo, input int hold);
      int cnt;
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("latency", 32'(cnt), 32'd4);
      chk("sum", 32'(sum), 32'(xs));
      chk("cout", 32'(cout), 32'(xc));
      chk("overflow", 32'(overflow), 32'(xo));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a = 16'($urandom); b = 16'($urandom);
         tick();
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_sum", 32'(sum), 32'(xs));
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("released_valid", 32'(out_valid), 32'd0);
      chk("released_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [15:0] ra, rb, es;
      logic        rc, rs, ec, eo;
      bit          seen;

      // Reset with garbage on the inputs.
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'b1; sub = 1'b0;
      tick();
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Directed cases.
      do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
      do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
      do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);

      // Backpressure: held for 3 cycles with in_valid asserted, then next op follows.
      do_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 3);
      do_op(16'h0100, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0, 0);

      // Mid-operation reset while idx = 2.
      a = 16'hABCD; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_sum", 32'(sum), 32'd0);
      chk("midrst_cout", 32'(cout), 32'd0);
      chk("midrst_overflow", 32'(overflow), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      chk("aborted_no_valid", 32'(seen), 32'd0);
      do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

      // Randomized operations against the reference model.
      for (int n = 0; n < 40; n++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         rc = 1'($urandom);  rs = 1'($urandom);
         if (n % 8 == 0) rb = ra;
         model(ra, rb, rc, rs, es, ec, eo);
         do_op(ra, rb, rc, rs, es, ec, eo, int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
